mux_scan_ctrl: RTL and testbench
================================

MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

Interface
REQ-001 Parameter NUM_CH, default 31: number of mux channels scanned, indices 0..NUM_CH-1.
REQ-002 Parameter DW, default 2: width of one mux channel.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 start  input  1  request one full scan; sampled only in IDLE.
REQ-006 abort  input  1  terminate any scan or held frame; highest priority after reset.
REQ-007 sel  output  5  registered channel select driven to the 31:1 mux.
REQ-008 mux_out  input  DW  combinational mux output for the current sel.
REQ-009 busy  output  1  high in SCAN or HOLD.
REQ-010 frame_valid  output  1  completed frame available.
REQ-011 frame_ready  input  1  downstream accepts the frame.
REQ-012 frame_data  output  NUM_CH*DW  captured frame; channel k occupies bits [DW*k +: DW].
REQ-013 start_drop  output  1  sticky flag: start seen high while not IDLE.

Function
REQ-014 The block SHALL implement the states IDLE, SCAN and HOLD.
REQ-015 IDLE->SCAN SHALL occur on a rising edge with start=1 and abort=0; that edge sets sel=0 and idx=0.
REQ-016 In SCAN, each rising edge SHALL capture mux_out into frame_data[DW*idx +: DW], then increment idx and sel.
REQ-017 On the edge capturing idx=NUM_CH-1, the block SHALL enter HOLD, set frame_valid=1 and set sel=0.
REQ-018 frame_valid SHALL rise on the 32nd rising edge, counting the start-sampling edge as edge 1; this is NUM_CH+1 cycles of latency.
REQ-019 sel SHALL never take the value 31, and SHALL be 0 in IDLE and HOLD.
REQ-020 In HOLD, frame_valid and frame_data SHALL remain stable until an edge with frame_valid=1 and frame_ready=1.
REQ-021 On that handshake edge the block SHALL clear frame_valid and go to IDLE.
REQ-022 If start=1 on the handshake edge, the block SHALL instead go directly to SCAN with sel=0, and start_drop SHALL NOT be set.
REQ-023 frame_ready SHALL be ignored outside HOLD.
REQ-024 start=1 in SCAN, or in HOLD without a handshake, SHALL set start_drop; the request is discarded and start_drop clears only on reset.
REQ-025 abort=1 in any state SHALL, on that edge, go to IDLE, clear frame_valid, set sel=0 and set idx=0; frame_data SHALL retain its partial contents.
REQ-026 Simultaneous abort and start SHALL resolve to IDLE; abort wins and start_drop is unchanged.
REQ-027 busy SHALL be a registered decode of the state: 1 in SCAN or HOLD.

Reset
REQ-028 rst_n=0 SHALL immediately force IDLE, sel=0, idx=0, frame_valid=0, busy=0, start_drop=0 and frame_data=0, independent of clk.
REQ-029 Reset deassertion mid-scan SHALL resume in IDLE, and no frame SHALL be produced until a new start.

Structure
REQ-030 Package mux_scan_pkg SHALL hold NUM_CH, DW, FRAME_W (NUM_CH*DW), SEL_W (5) and the state enum.
REQ-031 The block SHALL be a single module with no sub-module; the mux under test is instantiated only in the bench.

Verification
REQ-032 Set inp_k = k mod 4, pulse start for one cycle -> frame_valid rises on edge 32, and frame_data has each 2-bit slice k equal to k mod 4; sel steps 0..30 and never reaches 31.
REQ-033 Hold frame_ready=0 for 10 cycles after frame_valid -> frame_data is unchanged; raise frame_ready for one cycle -> frame_valid=0 and state is IDLE on the next edge.
REQ-034 Assert start together with frame_ready on the handshake edge -> new scan begins with sel=0 the next cycle, and start_drop remains 0.
REQ-035 Pulse start at sel=12 during SCAN -> start_drop=1, the scan still completes normally, and frame_valid occurs on edge 32.
REQ-036 Assert abort at sel=20 -> next cycle state is IDLE, sel=0 and busy=0; no frame_valid follows.
REQ-037 Drive rst_n low asynchronously mid-scan at sel=7 -> all outputs reach reset values before the next clk edge.

Source files
------------

// File: rtl/mux_scan_pkg.sv
// Shared sizing constants and state encoding for the 31:1 mux scan controller.
`timescale 1ns/1ps
`default_nettype none

package mux_scan_pkg;

  localparam int NUM_CH  = 31;
  localparam int DW      = 2;
  localparam int FRAME_W = NUM_CH * DW;
  localparam int SEL_W   = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_HOLD = 2'd2
  } scan_state_e;

endpackage

`default_nettype wire

// File: rtl/mux_scan_ctrl.sv
// Scans an external mux across all channels, one per clock, and holds the
// assembled frame until downstream accepts it with a valid/ready handshake.
`timescale 1ns/1ps
`default_nettype none

module mux_scan_ctrl #(
  parameter int NUM_CH = mux_scan_pkg::NUM_CH,
  parameter int DW     = mux_scan_pkg::DW
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic                             abort,
  output logic [mux_scan_pkg::SEL_W-1:0]   sel,
  input  logic [DW-1:0]                    mux_out,
  output logic                             busy,
  output logic                             frame_valid,
  input  logic                             frame_ready,
  output logic [NUM_CH*DW-1:0]             frame_data,
  output logic                             start_drop
);

  import mux_scan_pkg::SEL_W;
  import mux_scan_pkg::scan_state_e;
  import mux_scan_pkg::ST_IDLE;
  import mux_scan_pkg::ST_SCAN;
  import mux_scan_pkg::ST_HOLD;

  localparam int             FW       = NUM_CH * DW;
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_CH - 1);

  scan_state_e      state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic             fv_q, fv_d;
  logic             busy_q, busy_d;
  logic             drop_q, drop_d;
  logic [FW-1:0]    frame_q, frame_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      idx_q   <= '0;
      fv_q    <= 1'b0;
      busy_q  <= 1'b0;
      drop_q  <= 1'b0;
      frame_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      idx_q   <= idx_d;
      fv_q    <= fv_d;
      busy_q  <= busy_d;
      drop_q  <= drop_d;
      frame_q <= frame_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    idx_d   = idx_q;
    fv_d    = fv_q;
    drop_d  = drop_q;
    frame_d = frame_q;

    // Abort beats everything, including a coincident start; partial frame data is kept.
    if (abort) begin
      state_d = ST_IDLE;
      sel_d   = '0;
      idx_d   = '0;
      fv_d    = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d = ST_SCAN;
            sel_d   = '0;
            idx_d   = '0;
          end
        end

        ST_SCAN: begin
          frame_d[DW*idx_q +: DW] = mux_out;
          if (start) begin
            drop_d = 1'b1;
          end
          if (idx_q == LAST_IDX) begin
            state_d = ST_HOLD;
            fv_d    = 1'b1;
            sel_d   = '0;
            idx_d   = '0;
          end else begin
            sel_d = sel_q + SEL_W'(1);
            idx_d = idx_q + SEL_W'(1);
          end
        end

        ST_HOLD: begin
          if (frame_ready) begin
            // A start on the handshake edge chains straight into the next scan.
            fv_d  = 1'b0;
            sel_d = '0;
            idx_d = '0;
            state_d = start ? ST_SCAN : ST_IDLE;
          end else if (start) begin
            drop_d = 1'b1;
          end
        end

        default: begin
          state_d = ST_IDLE;
          sel_d   = '0;
          idx_d   = '0;
          fv_d    = 1'b0;
        end
      endcase
    end

    busy_d = (state_d != ST_IDLE);
  end

  assign sel         = sel_q;
  assign busy        = busy_q;
  assign frame_valid = fv_q;
  assign frame_data  = frame_q;
  assign start_drop  = drop_q;

endmodule

`default_nettype wire

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl with a behavioural 31:1 mux and a frame scoreboard.
`timescale 1ns/1ps
`default_nettype none

module tb_mux_scan_ctrl;

  localparam int NUM_CH = 31;
  localparam int DW     = 2;
  localparam int FW     = NUM_CH * DW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          frame_ready = 1'b0;
  logic [4:0]    sel;
  logic [DW-1:0] mux_out;
  logic          busy;
  logic          frame_valid;
  logic [FW-1:0] frame_data;
  logic          start_drop;

  logic [DW-1:0] inp [NUM_CH];
  logic [FW-1:0] exp_q [$];
  logic [FW-1:0] held;
  logic [FW-1:0] part;
  int            checks = 0;
  int            errors = 0;
  int            edge_n = 0;
  int            fv_seen;
  bit            scanning = 1'b0;

  always #5 clk = ~clk;

  always_comb mux_out = (sel < 5'(NUM_CH)) ? inp[sel] : '0;

  mux_scan_ctrl #(.NUM_CH(NUM_CH), .DW(DW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .sel         (sel),
    .mux_out     (mux_out),
    .busy        (busy),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .frame_data  (frame_data),
    .start_drop  (start_drop)
  );

  function automatic logic [FW-1:0] model_frame();
    logic [FW-1:0] f;
    f = '0;
    for (int k = 0; k < NUM_CH; k++) f[DW*k +: DW] = inp[k];
    return f;
  endfunction

  task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_pattern(input int mode);
    for (int k = 0; k < NUM_CH; k++) begin
      if (mode == 0)      inp[k] = DW'(k % 4);
      else if (mode == 1) inp[k] = DW'(3 - (k % 4));
      else                inp[k] = DW'($urandom_range(0, 3));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    edge_n++;
    chk("sel_below_31", FW'(sel < 5'd31), FW'(1));
    if (scanning && edge_n >= 2 && edge_n < 32) begin
      chk("sel_step", FW'(sel), FW'(edge_n - 1));
      chk("fv_low_in_scan", FW'(frame_valid), FW'(0));
    end
  endtask

  task automatic begin_scan(input bit expect_frame);
    start    = 1'b1;
    edge_n   = 0;
    scanning = 1'b1;
    if (expect_frame) exp_q.push_back(model_frame());
    tick();
    start       = 1'b0;
    frame_ready = 1'b0;
    chk("scan_sel0", FW'(sel), FW'(0));
    chk("scan_busy", FW'(busy), FW'(1));
    chk("scan_fv_low", FW'(frame_valid), FW'(0));
  endtask

  task automatic wait_frame();
    while (!frame_valid && edge_n < 60) tick();
    scanning = 1'b0;
    chk("fv_edge", FW'(edge_n), FW'(32));
    chk("hold_fv", FW'(frame_valid), FW'(1));
    chk("hold_sel0", FW'(sel), FW'(0));
    chk("hold_busy", FW'(busy), FW'(1));
    held = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
    chk("frame_data", frame_data, held);
  endtask

  task automatic handshake();
    frame_ready = 1'b1;
    tick();
    frame_ready = 1'b0;
    chk("hs_fv_clear", FW'(frame_valid), FW'(0));
    chk("hs_idle", FW'(busy), FW'(0));
  endtask

  task automatic run_to_sel(input logic [4:0] v);
    int n;
    n = 0;
    while (sel != v && n < 40) begin
      tick();
      n++;
    end
    chk("reach_sel", FW'(sel), FW'(v));
  endtask

  initial begin
    set_pattern(0);
    #1 rst_n = 1'b0;
    #12;
    chk("rst_sel", FW'(sel), FW'(0));
    chk("rst_busy", FW'(busy), FW'(0));
    chk("rst_fv", FW'(frame_valid), FW'(0));
    chk("rst_drop", FW'(start_drop), FW'(0));
    chk("rst_frame", frame_data, '0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    chk("idle_busy", FW'(busy), FW'(0));

    // Basic scan with inp_k = k mod 4
    set_pattern(0);
    begin_scan(1'b1);
    wait_frame();

    // Frame held while downstream stalls
    repeat (10) begin
      tick();
      chk("stall_frame", frame_data, held);
      chk("stall_fv", FW'(frame_valid), FW'(1));
    end
    handshake();
    tick();
    chk("post_hs_busy", FW'(busy), FW'(0));
    chk("post_hs_fv", FW'(frame_valid), FW'(0));

    // Start coincident with handshake chains into a new scan
    set_pattern(1);
    begin_scan(1'b1);
    wait_frame();
    set_pattern(2);
    frame_ready = 1'b1;
    begin_scan(1'b1);
    chk("chain_fv_clear", FW'(frame_valid), FW'(0));
    chk("chain_drop", FW'(start_drop), FW'(0));
    tick();
    chk("chain_sel1", FW'(sel), FW'(1));
    wait_frame();
    chk("chain_drop_end", FW'(start_drop), FW'(0));
    handshake();

    // Start during scan is dropped but the scan completes on time
    set_pattern(0);
    begin_scan(1'b1);
    run_to_sel(5'd12);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("drop_set", FW'(start_drop), FW'(1));
    wait_frame();
    handshake();
    chk("drop_sticky", FW'(start_drop), FW'(1));

    // Abort mid-scan keeps partial data and produces no frame
    set_pattern(1);
    begin_scan(1'b0);
    run_to_sel(5'd20);
    part = held;
    for (int k = 0; k < 20; k++) part[DW*k +: DW] = inp[k];
    abort    = 1'b1;
    scanning = 1'b0;
    tick();
    abort = 1'b0;
    chk("abort_busy", FW'(busy), FW'(0));
    chk("abort_sel", FW'(sel), FW'(0));
    chk("abort_fv", FW'(frame_valid), FW'(0));
    chk("abort_partial", frame_data, part);
    fv_seen = 0;
    repeat (40) begin
      tick();
      if (frame_valid) fv_seen++;
    end
    chk("abort_no_frame", FW'(fv_seen), FW'(0));

    // Abort and start together stay idle
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    chk("abort_start_busy", FW'(busy), FW'(0));
    chk("abort_start_sel", FW'(sel), FW'(0));
    chk("abort_start_drop", FW'(start_drop), FW'(1));

    // Asynchronous reset mid-scan
    set_pattern(0);
    begin_scan(1'b0);
    run_to_sel(5'd7);
    scanning = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_sel", FW'(sel), FW'(0));
    chk("arst_busy", FW'(busy), FW'(0));
    chk("arst_fv", FW'(frame_valid), FW'(0));
    chk("arst_drop", FW'(start_drop), FW'(0));
    chk("arst_frame", frame_data, '0);
    #3 rst_n = 1'b1;
    fv_seen = 0;
    repeat (40) begin
      tick();
      if (frame_valid || busy) fv_seen++;
    end
    chk("arst_quiet", FW'(fv_seen), FW'(0));

    // Fresh scan after reset
    set_pattern(2);
    begin_scan(1'b1);
    wait_frame();
    handshake();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
